fetch_ctrl: RTL

Instruction fetch/sequencing controller for the 8-bit CPU model. It drives the program counter's control inputs (IPC, IMPC, IJ, Din), fetches each instruction byte from program memory with a req/ack handshake and decodes the opcode class. It hands ALU-class instructions to the execute unit, then advances or redirects the PC. It sits between the PC block, program memory and the execute datapath, and is the only master of the PC control inputs.

---
 rtl/fetch_ctrl_if.sv | 21 ++
 rtl/fetch_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-side memory handshake and execute-unit handshake of fetch_ctrl.
// mem: mem_req is held for the whole fetch; a cycle with mem_req=1 and mem_ack=1 transfers mem_data.
interface fetch_ctrl_if;
  logic [5:0] mem_addr;
  logic       mem_req;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic       exe_go;
  logic       exe_done;
  logic       zf;

  modport master (
    output mem_addr, mem_req, exe_go,
    input  mem_ack, mem_data, exe_done, zf
  );

  modport slave (
    input  mem_addr, mem_req, exe_go,
    output mem_ack, mem_data, exe_done, zf
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch/sequencing controller: fetches a byte per instruction,
// decodes the opcode class, dispatches ALU ops and drives the PC controls.
module fetch_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [5:0]   pc_val,
  fetch_ctrl_if.master bus,
  output logic [7:0]   ir,
  output logic         IPC,
  output logic         IMPC,
  output logic         IJ,
  output logic [7:0]   Din,
  output logic         halted,
  output logic         fault,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_INC    = 3'd4,
    S_JUMP   = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [7:0] L_TMO    = 8'(TIMEOUT);
  localparam logic [7:0] L_TMO_M1 = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_ir;
  logic [7:0] r_wait;
  logic [7:0] w_next_wait;
  logic       w_ir_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ir    <= 8'h00;
      r_wait  <= 8'd0;
    end else begin
      r_state <= w_next_state;
      r_wait  <= w_next_wait;
      if (w_ir_load) r_ir <= bus.mem_data;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_wait  = r_wait;
    w_ir_load    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        if (bus.mem_ack) begin
          w_ir_load    = 1'b1;
          w_next_state = S_DECODE;
        end else if (r_wait == L_TMO_M1) begin
          w_next_state = S_FAULT;
        end else begin
          w_next_wait = r_wait + 8'd1;
        end
      end
      S_DECODE: begin
        unique case (r_ir[7:6])
          2'b00:   w_next_state = S_EXEC;
          2'b01:   w_next_state = S_JUMP;
          2'b10:   w_next_state = bus.zf ? S_JUMP : S_INC;
          default: w_next_state = (r_ir[5:0] == 6'h3F) ? S_HALT : S_INC;
        endcase
      end
      S_EXEC: begin
        // r_wait==0 marks the dispatch cycle; exe_done is only trusted after it.
        if (r_wait == 8'd0) begin
          w_next_wait = 8'd1;
        end else if (bus.exe_done) begin
          w_next_state = S_INC;
        end else if (r_wait == L_TMO) begin
          w_next_state = S_FAULT;
        end else begin
          w_next_wait = r_wait + 8'd1;
        end
      end
      S_INC:   w_next_state = S_FETCH;
      S_JUMP:  w_next_state = S_FETCH;
      default: w_next_state = r_state;
    endcase
    if (w_next_state != r_state) w_next_wait = 8'd0;
  end

  assign bus.mem_addr = pc_val;
  assign bus.mem_req  = (r_state == S_FETCH);
  assign bus.exe_go   = (r_state == S_EXEC) && (r_wait == 8'd0);
  assign ir           = r_ir;
  assign IPC          = (r_state == S_INC);
  assign IMPC         = (r_state == S_JUMP);
  assign IJ           = (r_state == S_JUMP);
  assign Din          = (r_state == S_JUMP) ? {2'b00, r_ir[5:0]} : 8'h00;
  assign halted       = (r_state == S_HALT);
  assign fault        = (r_state == S_FAULT);
  assign state        = r_state;

endmodule
